// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format select encoding and buffer depth.
// Latency/backpressure: n/a (package only).
// Imported by imm_extract and imm_gen_pipe.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_BAD = 3'd7
    } imm_sel_e;

    localparam int IMM_BUF_DEPTH = 2;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction/extension for all formats, XLEN 32 or 64.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing buffer handles flow control.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     Instruction,
    input  logic [2:0]      Imm_Ctrl,
    output logic [XLEN-1:0] Immediate,
    output logic            illegal
);

    // Sign-extended formats are built as a signed 32-bit value, then widened to XLEN.
    logic signed [31:0] sx;
    logic        [5:0]  zx;
    logic               use_z;

    always_comb begin
        sx      = '0;
        zx      = '0;
        use_z   = 1'b0;
        illegal = 1'b0;
        case (imm_sel_e'(Imm_Ctrl))
            IMM_I:   sx = {{20{Instruction[31]}}, Instruction[31:20]};
            IMM_S:   sx = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
            IMM_B:   sx = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                           Instruction[30:25], Instruction[11:8], 1'b0};
            IMM_J:   sx = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                           Instruction[20], Instruction[30:21], 1'b0};
            IMM_U:   sx = {Instruction[31:12], 12'b0};
            IMM_Z: begin
                use_z = 1'b1;
                zx    = {1'b0, Instruction[19:15]};
            end
            IMM_SH: begin
                use_z = 1'b1;
                zx    = (XLEN == 64) ? Instruction[25:20] : {1'b0, Instruction[24:20]};
            end
            default: illegal = 1'b1;
        endcase
        Immediate = use_z ? XLEN'(zx) : XLEN'(sx);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with 2-entry skid buffer between ID and EX; IMM_ILLEGAL_EN adds out_illegal.
// Latency: 1 cycle from accept to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready is registered and drops only when both entries are occupied.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instruction,
    input  logic [2:0]       Imm_Ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  Immediate,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_EN
    ,
    output logic             out_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_EN
        logic             ill;
`endif
    } ent_t;

    logic [XLEN-1:0] new_imm;
    ent_t            ent_new;
    ent_t            ent_q [IMM_BUF_DEPTH];
    ent_t            head;
    logic            wr_ptr, rd_ptr;
    logic [1:0]      state, state_nxt;
    logic            accept, pop;

`ifdef IMM_ILLEGAL_EN
    logic new_ill;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .Instruction (Instruction),
        .Imm_Ctrl    (Imm_Ctrl),
        .Immediate   (new_imm),
        .illegal     (new_ill)
    );
`else
    imm_extract #(.XLEN(XLEN)) u_extract (
        .Instruction (Instruction),
        .Imm_Ctrl    (Imm_Ctrl),
        .Immediate   (new_imm),
        .illegal     ()
    );
`endif

    always_comb begin
        ent_new     = '0;
        ent_new.imm = new_imm;
        ent_new.tag = in_tag;
`ifdef IMM_ILLEGAL_EN
        ent_new.ill = new_ill;
`endif
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !pop)      state_nxt = ST_FULL;
                else if (pop && !accept) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Flush wins over accept/pop: pointers realign and the offered entry is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
            for (int i = 0; i < IMM_BUF_DEPTH; i++) ent_q[i] <= '0;
        end else if (flush) begin
            state    <= ST_EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (accept) begin
                ent_q[wr_ptr] <= ent_new;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    assign head      = ent_q[rd_ptr];
    assign out_valid = (state != ST_EMPTY);
    assign Immediate = head.imm;
    assign out_tag   = head.tag;
`ifdef IMM_ILLEGAL_EN
    assign out_illegal = head.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32-bit instance driven through a scoreboard, 64-bit instance for wide formats.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] Instruction, in_tag, out_tag, Immediate;
    logic [2:0]  Imm_Ctrl;
    logic        stream_chk;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, flush64;
    logic [31:0] ins64, in_tag64, out_tag64;
    logic [2:0]  ctrl64;
    logic [63:0] imm64;

`ifdef IMM_ILLEGAL_EN
    logic out_illegal, out_illegal64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .Imm_Ctrl(Imm_Ctrl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .Immediate(Immediate), .out_tag(out_tag)
`ifdef IMM_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .Instruction(ins64), .Imm_Ctrl(ctrl64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .Immediate(imm64), .out_tag(out_tag64)
`ifdef IMM_ILLEGAL_EN
        , .out_illegal(out_illegal64)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        return v[w-1] ? (v | (~64'h0 << w)) : v;
    endfunction

    // Reference decode written from the format table, independent of the RTL structure.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] c, input int xl);
        logic [63:0] r;
        case (c)
            3'd0: r = sx({52'b0, ins[31:20]}, 12);
            3'd1: r = sx({52'b0, ins[31:25], ins[11:7]}, 12);
            3'd2: r = sx({51'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            3'd3: r = sx({43'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            3'd4: r = sx({32'b0, ins[31:12], 12'b0}, 32);
            3'd5: r = {59'b0, ins[19:15]};
            3'd6: r = (xl == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
            default: r = 64'h0;
        endcase
        if (xl == 32) r[63:32] = 32'h0;
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] tmp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_pop", 64'(sb.size()), 64'd1);
                else begin
                    e = sb.pop_front();
                    chk("sb_imm", {32'h0, Immediate}, {32'h0, e.imm});
                    chk("sb_tag", {32'h0, out_tag}, {32'h0, e.tag});
`ifdef IMM_ILLEGAL_EN
                    chk("sb_ill", {63'h0, out_illegal}, {63'h0, e.ill});
`endif
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) begin
                tmp = ref_imm(Instruction, Imm_Ctrl, 32);
                sb.push_back('{imm: tmp[31:0], tag: in_tag, ill: (Imm_Ctrl == 3'd7)});
            end
            if (stream_chk) begin
                chk("stream_in_ready", {63'h0, in_ready}, 64'd1);
                chk("stream_out_valid", {63'h0, out_valid}, 64'd1);
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [2:0] c, input logic [31:0] t);
        Instruction = ins;
        Imm_Ctrl    = c;
        in_tag      = t;
        in_valid    = 1'b1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] c, input logic [31:0] t);
        bit ok = 0;
        drive(ins, c, t);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        chk(tag, {63'h0, out_valid}, 64'd0);
    endtask

    task automatic t64(input string tag, input logic [31:0] ins, input logic [2:0] c,
                       input logic [63:0] exp);
        ins64      = ins;
        ctrl64     = c;
        in_valid64 = 1'b1;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, {63'h0, out_valid64}, 64'd1);
        chk(tag, imm64, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Instruction = '0; Imm_Ctrl = '0; in_tag = '0; stream_chk = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; flush64 = 1'b0;
        ins64 = '0; ctrl64 = '0; in_tag64 = 32'h64;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
        chk("rst_imm", {32'h0, Immediate}, 64'd0);
        chk("rst_tag", {32'h0, out_tag}, 64'd0);
        rst_n = 1'b1;

        // B-type latency and value
        out_ready = 1'b1;
        drive(32'hFE000EE3, 3'd2, 32'd100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_out_valid", {63'h0, out_valid}, 64'd1);
        chk("b_imm", {32'h0, Immediate}, 64'h0000_0000_FFFF_FFFC);
        wait_empty("b_drain");

        // Wide formats on the 64-bit instance
        t64("u64", 32'h800002B7, 3'd4, 64'hFFFF_FFFF_8000_0000);
        t64("sh64", 32'h03F05013, 3'd6, 64'h3F);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] r = $urandom;
            t64("rnd64", r, 3'(i), ref_imm(r, 3'(i), 64));
        end

        // Streaming: one accept and one pop per cycle
        for (int i = 0; i < 24; i++) begin
            send($urandom, 3'($urandom_range(0, 7)), 32'(200 + i));
            if (i == 0) stream_chk = 1'b1;
        end
        stream_chk = 1'b0;
        in_valid   = 1'b0;
        wait_empty("stream_drain");

        // Backpressure: three back-to-back offers, two accepted
        out_ready = 1'b0;
        drive(32'h80000013, 3'd0, 32'd300);
        @(posedge clk); #1;
        drive(32'hFE1FAFA3, 3'd1, 32'd301);
        @(posedge clk); #1;
        drive(32'h7FFFF06F, 3'd3, 32'd302);
        @(negedge clk);
        chk("full_in_ready", {63'h0, in_ready}, 64'd0);
        chk("full_out_valid", {63'h0, out_valid}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("hold_tag", {32'h0, out_tag}, 64'd300);
            chk("hold_imm", {32'h0, Immediate}, 64'h0000_0000_FFFF_F800);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_empty("bp_drain");
        chk("bp_sb_left", 64'(sb.size()), 64'd0);

        // Flush from FULL with an input offered
        out_ready = 1'b0;
        drive(32'h00500093, 3'd0, 32'd400);
        @(posedge clk); #1;
        drive(32'h12345037, 3'd4, 32'd401);
        @(posedge clk); #1;
        drive(32'h000F5073, 3'd5, 32'd402);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'h0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'h0, in_ready}, 64'd1);
        // Flush while empty and ready: offered input must be dropped
        @(posedge clk); #1;
        drive(32'h00A00113, 3'd0, 32'd404);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop", {63'h0, out_valid}, 64'd0);
        out_ready = 1'b1;
        send(32'h01F05013, 3'd6, 32'd403);
        in_valid = 1'b0;
        wait_empty("flush_drain");
        chk("flush_sb_left", 64'(sb.size()), 64'd0);

        // Async reset with two entries buffered
        out_ready = 1'b0;
        drive(32'h12345037, 3'd4, 32'd500);
        @(posedge clk); #1;
        drive(32'hABCDE0B7, 3'd4, 32'd501);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_tag", {32'h0, out_tag}, 64'd500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_imm", {32'h0, Immediate}, 64'd0);
        chk("arst_tag", {32'h0, out_tag}, 64'd0);
        chk("arst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'h0, in_ready}, 64'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Illegal format
        send(32'hFFFFFFFF, 3'd7, 32'd600);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bad_imm", {32'h0, Immediate}, 64'd0);
`ifdef IMM_ILLEGAL_EN
        chk("bad_illegal", {63'h0, out_illegal}, 64'd1);
`endif
        out_ready = 1'b1;
        wait_empty("bad_drain");
        chk("final_sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
